ethernet_encapsulation: RTL and testbench

ETHERNET_ENCAPSULATION -- requirements
Module: ethernet_encapsulation

---
 rtl/eth_pkg.sv | 52 +++++
 rtl/crc32_d8.sv | 46 ++++
 rtl/ethernet_encapsulation.sv | 238 +++++++++++++++++++++++
 tb/tb_ethernet_encapsulation.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state encoding and byte helpers.
// Used by the encapsulation and decapsulation paths alike.
package eth_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DST,
    SRC,
    LEN,
    PAYLOAD,
    PAD,
    FCS,
    IFG,
    ABORT
  } eth_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [10:0] MIN_PAYLOAD   = 11'd46;
  localparam logic [10:0] MAX_PAYLOAD   = 11'd1500;
  localparam logic [10:0] IFG_CYCLES    = 11'd12;
  localparam logic [10:0] PREAMBLE_LEN  = 11'd7;
  localparam logic [10:0] MAC_LEN       = 11'd6;
  localparam logic [10:0] FCS_LEN       = 11'd4;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Byte idx of a MAC address, transmitted most significant byte first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Ethernet CRC-32, one byte per cycle, reflected LSB-first register; result visible the cycle after en.
// No backpressure: init has priority over en; the register holds when neither is set.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] step;

  always_comb begin
    step = crc_q ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      step = step[0] ? ((step >> 1) ^ POLY_REFL) : (step >> 1);
    end
  end

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ethernet_encapsulation.sv
// Wraps a payload stream into a GMII Ethernet frame (preamble, header, pad, FCS, IFG); TX_EN rises the cycle after request.
// Payload is pulled with combinational data_ready; a missing byte mid-payload aborts the frame with TX_ER.
module ethernet_encapsulation
  import eth_pkg::*;
#(
  parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
  parameter logic [47:0] source_mac_addr      = 48'h072227acdb65
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pct_qued,
  input  logic [10:0] pct_len,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  gmii_data_out,
  output logic        gmii_dv,
  output logic        gmii_er,
  output logic        busy,
  output logic        len_err,
  output logic        pct_txed
);

  eth_state_e  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] rem_q, rem_d;
  logic [10:0] len_q, len_d;
  logic        len_err_q, len_err_d;
  logic        pct_txed_q, pct_txed_d;
  logic [1:0]  rst_sync_q, rst_sync_d;

  logic        rst_ok;
  logic        len_ok;
  logic        crc_init;
  logic        crc_en;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  // Requests are only honoured once reset release has passed through two flops.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_ok     = rst_sync_q[1];
  assign len_ok     = (pct_len != 11'd0) && (pct_len <= MAX_PAYLOAD);
  assign fcs        = ~crc;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    len_d         = len_q;
    len_err_d     = 1'b0;
    pct_txed_d    = 1'b0;
    data_ready    = 1'b0;
    gmii_data_out = 8'h00;
    gmii_dv       = 1'b0;
    gmii_er       = 1'b0;
    crc_init      = 1'b0;
    crc_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (rst_ok && pct_qued) begin
          if (len_ok) begin
            len_d   = pct_len;
            rem_d   = pct_len;
            cnt_d   = 11'd0;
            state_d = PREAMBLE;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        gmii_dv       = 1'b1;
        gmii_data_out = PREAMBLE_BYTE;
        if (cnt_q == PREAMBLE_LEN - 11'd1) begin
          cnt_d   = 11'd0;
          state_d = SFD;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      SFD: begin
        gmii_dv       = 1'b1;
        gmii_data_out = SFD_BYTE;
        crc_init      = 1'b1;
        state_d       = DST;
      end

      DST: begin
        gmii_dv       = 1'b1;
        gmii_data_out = mac_byte(destination_mac_addr, cnt_q[2:0]);
        crc_en        = 1'b1;
        if (cnt_q == MAC_LEN - 11'd1) begin
          cnt_d   = 11'd0;
          state_d = SRC;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      SRC: begin
        gmii_dv       = 1'b1;
        gmii_data_out = mac_byte(source_mac_addr, cnt_q[2:0]);
        crc_en        = 1'b1;
        if (cnt_q == MAC_LEN - 11'd1) begin
          cnt_d   = 11'd0;
          state_d = LEN;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      LEN: begin
        gmii_dv       = 1'b1;
        gmii_data_out = (cnt_q == 11'd0) ? {5'd0, len_q[10:8]} : len_q[7:0];
        crc_en        = 1'b1;
        if (cnt_q == 11'd1) begin
          cnt_d   = 11'd0;
          state_d = PAYLOAD;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      PAYLOAD: begin
        data_ready = 1'b1;
        gmii_dv    = 1'b1;
        if (data_valid) begin
          gmii_data_out = data_in;
          crc_en        = 1'b1;
          rem_d         = rem_q - 11'd1;
          if (rem_q == 11'd1) begin
            if (len_q < MIN_PAYLOAD) begin
              cnt_d   = MIN_PAYLOAD - len_q;
              state_d = PAD;
            end else begin
              cnt_d   = 11'd0;
              state_d = FCS;
            end
          end
        end else begin
          // Underrun: flag the frame as corrupt and never send a valid FCS.
          gmii_er = 1'b1;
          cnt_d   = 11'd0;
          state_d = ABORT;
        end
      end

      PAD: begin
        gmii_dv = 1'b1;
        crc_en  = 1'b1;
        cnt_d   = cnt_q - 11'd1;
        if (cnt_q == 11'd1) begin
          cnt_d   = 11'd0;
          state_d = FCS;
        end
      end

      FCS: begin
        gmii_dv       = 1'b1;
        gmii_data_out = fcs_byte;
        if (cnt_q == FCS_LEN - 11'd1) begin
          cnt_d      = 11'd0;
          pct_txed_d = 1'b1;
          state_d    = IFG;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      IFG: begin
        if (cnt_q == IFG_CYCLES - 11'd1) begin
          cnt_d   = 11'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      ABORT: begin
        cnt_d   = 11'd0;
        rem_d   = 11'd0;
        state_d = IFG;
      end

      default: begin
        cnt_d   = 11'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 11'd0;
      rem_q      <= 11'd0;
      len_q      <= 11'd0;
      len_err_q  <= 1'b0;
      pct_txed_q <= 1'b0;
      rst_sync_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
      pct_txed_q <= pct_txed_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign len_err  = len_err_q;
  assign pct_txed = pct_txed_q;

  crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst),
    .init  (crc_init),
    .en    (crc_en),
    .data  (gmii_data_out),
    .crc   (crc)
  );

endmodule

// File: tb/tb_ethernet_encapsulation.sv
// Randomized frame bench for ethernet_encapsulation against a byte-list frame model with software CRC-32.
module tb_ethernet_encapsulation;

  localparam logic [47:0] DST_MAC = 48'h023528fbdd66;
  localparam logic [47:0] SRC_MAC = 48'h072227acdb65;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pct_qued = 1'b0;
  logic [10:0] pct_len = 11'd0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [7:0]  gmii_data_out;
  logic        gmii_dv;
  logic        gmii_er;
  logic        busy;
  logic        len_err;
  logic        pct_txed;

  always #5 clk = ~clk;

  ethernet_encapsulation #(
    .destination_mac_addr (DST_MAC),
    .source_mac_addr      (SRC_MAC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pct_qued      (pct_qued),
    .pct_len       (pct_len),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .gmii_data_out (gmii_data_out),
    .gmii_dv       (gmii_dv),
    .gmii_er       (gmii_er),
    .busy          (busy),
    .len_err       (len_err),
    .pct_txed      (pct_txed)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_raw(input byte unsigned q[$], input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  byte unsigned exp_q[$];
  byte unsigned pay[$];

  task automatic build_exp(input int len);
    logic [47:0] t;
    logic [31:0] f;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) begin t = DST_MAC >> (40 - 8*i); exp_q.push_back(t[7:0]); end
    for (int i = 0; i < 6; i++) begin t = SRC_MAC >> (40 - 8*i); exp_q.push_back(t[7:0]); end
    exp_q.push_back(len / 256);
    exp_q.push_back(len % 256);
    for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
    for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
    f = ~crc_raw(exp_q, 8, exp_q.size());
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[31:24]);
  endtask

  // ---------------- payload source ----------------
  int   pidx = 0;
  int   drop_at = -1;
  logic take;

  task automatic drive_payload();
    if (pidx < pay.size() && pidx != drop_at) begin
      data_valid = 1'b1;
      data_in    = pay[pidx];
    end else begin
      data_valid = 1'b0;
      data_in    = 8'h00;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      take = data_ready && data_valid;
      @(posedge clk);
      #1;
      if (take) pidx++;
      drive_payload();
    end
  end

  // ---------------- output monitor ----------------
  byte unsigned cap[$];
  int dv_cyc, er_cnt, txed_cnt, txed_bad, lerr_cnt, busy_cnt, zviol, rdy_viol, ifg_cnt;
  int low_run, hi_run;
  int gaps[$];
  int runs[$];
  logic prev_dv = 1'b0;

  task automatic clear_mon();
    cap.delete(); gaps.delete(); runs.delete();
    dv_cyc = 0; er_cnt = 0; txed_cnt = 0; txed_bad = 0; lerr_cnt = 0;
    busy_cnt = 0; zviol = 0; rdy_viol = 0; ifg_cnt = 0; low_run = 0; hi_run = 0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (gmii_dv) begin
        if (!prev_dv) gaps.push_back(low_run);
        low_run = 0;
        hi_run++;
        dv_cyc++;
        cap.push_back(gmii_data_out);
      end else begin
        if (prev_dv) runs.push_back(hi_run);
        hi_run = 0;
        low_run++;
        if (gmii_data_out != 8'h00) zviol++;
      end
      if (gmii_er) er_cnt++;
      if (pct_txed) begin
        txed_cnt++;
        if (!(prev_dv && !gmii_dv)) txed_bad++;
      end
      if (len_err) lerr_cnt++;
      if (busy) busy_cnt++;
      if (busy && !gmii_dv) ifg_cnt++;
      if (data_ready && !gmii_dv) rdy_viol++;
      prev_dv = gmii_dv;
    end
  end

  // ---------------- test helpers ----------------
  task automatic wait_idle(input string tag);
    int to;
    to = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) begin to = 0; break; end
    end
    check_eq({tag, "_timeout"}, to, 0);
  endtask

  task automatic start_req(input int len);
    @(posedge clk); #1;
    pct_qued = 1'b1;
    pct_len  = len[10:0];
    @(posedge clk); #1;
    pct_qued = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int len, input int drop, input bit mid_qued);
    int nbad;
    int n;
    @(negedge clk);
    pidx = 0;
    drop_at = drop;
    drive_payload();
    clear_mon();
    start_req(len);
    @(negedge clk);
    check_eq({tag, "_dv_rise"}, gmii_dv, 1'b1);
    if (mid_qued) begin
      repeat (30) @(posedge clk);
      #1; pct_qued = 1'b1; pct_len = 11'd50;
      @(posedge clk); #1; pct_qued = 1'b0;
    end
    wait_idle(tag);
    if (drop >= 0) begin
      check_eq({tag, "_dv_cycles"}, dv_cyc, 8 + 14 + drop + 1);
      check_eq({tag, "_er_cnt"}, er_cnt, 1);
      check_eq({tag, "_txed_cnt"}, txed_cnt, 0);
      check_eq({tag, "_ifg_ok"}, (ifg_cnt >= 12 && ifg_cnt <= 13), 1'b1);
    end else begin
      build_exp(len);
      n = cap.size();
      check_eq({tag, "_frame_len"}, n, exp_q.size());
      nbad = 0;
      for (int i = 0; i < n && i < exp_q.size(); i++) if (cap[i] != exp_q[i]) nbad++;
      check_eq({tag, "_bad_bytes"}, nbad, 0);
      if (n >= 26) begin
        check_eq({tag, "_fcs"}, {cap[n-1], cap[n-2], cap[n-3], cap[n-4]},
                 {exp_q[n-1], exp_q[n-2], exp_q[n-3], exp_q[n-4]});
        check_eq({tag, "_len_field"}, {cap[20], cap[21]}, len);
      end
      check_eq({tag, "_residue"}, rev32(crc_raw(cap, 8, n)), 32'hC704DD7B);
      check_eq({tag, "_txed_cnt"}, txed_cnt, 1);
      check_eq({tag, "_txed_at_fall"}, txed_bad, 0);
      check_eq({tag, "_er_cnt"}, er_cnt, 0);
      check_eq({tag, "_ifg_cycles"}, ifg_cnt, 12);
    end
    check_eq({tag, "_zero_when_idle"}, zviol, 0);
    check_eq({tag, "_ready_outside"}, rdy_viol, 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_stays_idle"}, busy, 1'b0);
  endtask

  task automatic fill_random(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back($urandom_range(0, 255));
  endtask

  task automatic bad_len(input string tag, input int len);
    @(negedge clk);
    clear_mon();
    start_req(len);
    @(negedge clk);
    check_eq({tag, "_len_err_pulse"}, len_err, 1'b1);
    repeat (4) @(negedge clk);
    check_eq({tag, "_len_err_cnt"}, lerr_cnt, 1);
    check_eq({tag, "_no_dv"}, dv_cyc, 0);
    check_eq({tag, "_no_busy"}, busy_cnt, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    #23;
    check_eq("rst_dv", gmii_dv, 1'b0);
    check_eq("rst_data", gmii_data_out, 8'h00);
    check_eq("rst_er", gmii_er, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", data_ready, 1'b0);
    check_eq("rst_txed_lerr", {pct_txed, len_err}, 2'b00);

    pct_qued = 1'b1;
    pct_len  = 11'd46;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("no_accept_edge1", busy, 1'b0);
    pct_qued = 1'b0;
    repeat (5) @(negedge clk);

    pay.delete();
    for (int i = 0; i < 46; i++) pay.push_back(i);
    run_frame("len46", 46, -1, 1'b0);

    pay.delete();
    pay.push_back(8'hAB);
    run_frame("len1", 1, -1, 1'b0);

    fill_random(45);
    run_frame("len45", 45, -1, 1'b0);

    bad_len("len0", 0);
    bad_len("len1501", 1501);

    fill_random(40);
    run_frame("underrun", 40, 10, 1'b0);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 200);
      fill_random(n);
      run_frame($sformatf("rand%0d", k), n, -1, (k == 1));
    end

    // Back-to-back maximum frames with request held high.
    fill_random(3000);
    @(negedge clk);
    pidx = 0; drop_at = -1;
    drive_payload();
    clear_mon();
    @(posedge clk); #1;
    pct_qued = 1'b1; pct_len = 11'd1500;
    for (int i = 0; i < 4000 && runs.size() == 0; i++) @(negedge clk);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    @(posedge clk); #1;
    pct_qued = 1'b0;
    wait_idle("b2b");
    check_eq("b2b_frames", runs.size(), 2);
    if (runs.size() == 2) begin
      check_eq("b2b_run0", runs[0], 1526);
      check_eq("b2b_run1", runs[1], 1526);
    end
    if (gaps.size() >= 2) check_eq("b2b_gap", gaps[1], 13);
    check_eq("b2b_txed", txed_cnt, 2);
    if (cap.size() == 3052) begin
      check_eq("b2b_res0", rev32(crc_raw(cap, 8, 1526)), 32'hC704DD7B);
      check_eq("b2b_res1", rev32(crc_raw(cap, 1534, 3052)), 32'hC704DD7B);
    end

    // Reset in the middle of the source address.
    fill_random(60);
    @(negedge clk);
    pidx = 0; drop_at = -1;
    drive_payload();
    clear_mon();
    start_req(60);
    @(negedge clk);
    repeat (17) @(negedge clk);
    check_eq("src_byte3", gmii_data_out, 8'hAC);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_dv", gmii_dv, 1'b0);
    check_eq("mid_rst_data", gmii_data_out, 8'h00);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_ready", data_ready, 1'b0);
    check_eq("mid_rst_er_txed", {gmii_er, pct_txed}, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    pay.delete();
    drive_payload();
    clear_mon();
    repeat (20) @(negedge clk);
    check_eq("post_rst_no_resume", dv_cyc + busy_cnt, 0);

    fill_random(100);
    run_frame("after_rst", 100, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
